fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage feeding the Decode stage of the 20-bit-instruction / 19-bit-datapath pipeline. It owns the program counter and issues one-at-a-time requests to a variable-latency instruction memory. It drives the IF/ID pipeline register (`InstrD`, `PCD`, `ValidD`), honouring stall, flush and taken-branch/jump redirects from Execute.

## Interface
Parameters:
- `RESET_PC`, default 15'h0000: PC after reset.
- `IW`, default 20: instruction width.
- `PW`, default 15: PC width; the PC is word-addressed, one instruction per address.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `StallD`  in  1  hold the IF/ID register and the PC.
- `FlushD`  in  1  replace the IF/ID contents with a bubble.
- `PCSrcE`  in  1  redirect request from Execute.
- `PCTargetE`  in  PW  redirect target.
- `imem_req`  out  1  one-cycle request strobe.
- `imem_addr`  out  PW  request address; valid while `imem_req`=1.
- `imem_ack`  in  1  response valid, one cycle, at least one cycle after `imem_req`.
- `imem_rdata`  in  IW  instruction; valid while `imem_ack`=1.
- `InstrD`  out  IW  instruction to Decode.
- `PCD`  out  PW  PC of `InstrD`.
- `ValidD`  out  1  1 = real instruction, 0 = bubble.

## Operation
- Registers:
  - `PCF`.
  - FSM state.
  - `discard` flag.
  - One-entry buffer (`buf_instr`, `buf_pc`).
  - IF/ID register (`InstrD`, `PCD`, `ValidD`).
- FSM states:
  - **IDLE**: present only after reset; goes to REQ unconditionally.
  - **REQ**: `imem_req`=1, `imem_addr`=`PCF`; goes to WAIT.
  - **WAIT**: waits for `imem_ack`.
    - Ack with `discard`=1: drop the data, clear `discard`, go to REQ.
    - Ack with `PCSrcE`=1: drop the data, go to REQ.
    - Ack with `StallD`=1: capture the data into the buffer, go to HOLD.
    - Otherwise: load IF/ID with `imem_rdata` / `PCF` / `ValidD`=1, set `PCF`←`PCF`+1, go to REQ.
  - **HOLD**: waits for the stall to release.
    - `PCSrcE`=1: drop the buffer, go to REQ.
    - `StallD`=0: load IF/ID from the buffer, set `PCF`←`PCF`+1, go to REQ.
- Redirect:
  - `PCSrcE`=1 in any state sets `PCF`←`PCTargetE`.
  - In REQ the request still goes out with the old address, and `discard` is set.
  - In WAIT without an ack, `discard` is set.
- IF/ID update, priority order:
  1. `FlushD`: bubble.
  2. `StallD`: hold.
  3. Fresh instruction from WAIT/HOLD: load it.
  4. Otherwise: bubble. Decode samples every cycle, so idle cycles must inject bubbles.
- Bubble: `InstrD`=`NOP_INSTR` (20'h00000), `PCD`=0, `ValidD`=0.
- PC arithmetic is modulo 2^PW: 15'h7FFF+1 = 15'h0000.
- `StallD` freezes `PCF`, but it does not block a redirect.

## Timing
- Reset values (asynchronous, effective immediately):
  - State IDLE, `PCF`=`RESET_PC`, `discard`=0, buffer 0.
  - `InstrD`=0, `PCD`=0, `ValidD`=0, `imem_req`=0, `imem_addr`=`PCF`.
- First `imem_req`: second rising edge after `reset` deasserts (IDLE takes one cycle).
- Latency: an instruction acked in cycle N appears on `InstrD` after edge N (visible in cycle N+1), if not stalled.
- Throughput: one instruction per (memory latency + 1) cycles; at most one request outstanding.
- Reset asserted mid-request: the outstanding response is ignored, because the FSM is in IDLE/REQ and only acts on `imem_ack` in WAIT.
- `imem_ack` outside WAIT is ignored.
- `FlushD` and `StallD` together: flush wins.

## Structure
- Shared package `fetch_pkg`:
  - `NOP_INSTR`.
  - FSM enum `fetch_state_t` {IDLE, REQ, WAIT, HOLD}.
  - `IW`/`PW` defaults, shared with the Decode stage.
- One natural sub-module: `fetch_buffer`, the one-entry instruction/PC holding register with load/clear. Everything else is in `fetch_stage`.

## Test plan
- Reset release, `RESET_PC`=0x0010, 1-cycle memory returning 20'hABCDE: `imem_req` at cycle 2 with addr 0x0010. Next cycle `InstrD`=20'hABCDE, `PCD`=0x0010, `ValidD`=1. Next request addr is 0x0011.
- 3-cycle memory latency: `ValidD` is 0 (bubble, `InstrD`=0) on the 3 cycles between instructions; the PCs are consecutive.
- `StallD`=1 for 4 cycles starting the cycle of an ack: FSM enters HOLD and `InstrD` holds the prior value. On release, the buffered instruction loads and exactly one copy appears.
- `PCSrcE`=1, `PCTargetE`=0x0200 while in WAIT, ack arrives 2 cycles later with 20'h11111: 20'h11111 never reaches `InstrD`. Next `imem_addr`=0x0200.
- `PCF`=0x7FFF fetched and not stalled: next `imem_addr`=0x0000.
- `FlushD`=1 coincident with `StallD`=1 and an ack: `ValidD`=0 and `InstrD`=0 next cycle. The acked instruction is buffered, not lost.

Source files
------------

// File: rtl/fetch_pkg.sv
// Definitions shared by the fetch and decode stages: default widths,
// the bubble instruction encoding and the fetch FSM state type.
package fetch_pkg;

  localparam int IW_DEF = 20;
  localparam int PW_DEF = 15;

  localparam logic [IW_DEF-1:0] NOP_INSTR = 20'h00000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry instruction/PC holding register that parks an acked
// instruction while Decode is stalled; load has priority over clear.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          clear_i,
  input  logic [IW-1:0] instr_i,
  input  logic [PW-1:0] pc_i,
  output logic [IW-1:0] instr_o,
  output logic [PW-1:0] pc_o
);

  logic [IW-1:0] instr_q, instr_d;
  logic [PW-1:0] pc_q, pc_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    if (load_i) begin
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (clear_i) begin
      instr_d = '0;
      pc_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one memory request in
// flight and drives the IF/ID register under stall, flush and redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int            IW       = IW_DEF,
  parameter int            PW       = PW_DEF,
  parameter logic [PW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          StallD,
  input  logic          FlushD,
  input  logic          PCSrcE,
  input  logic [PW-1:0] PCTargetE,
  output logic          imem_req,
  output logic [PW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic [IW-1:0] InstrD,
  output logic [PW-1:0] PCD,
  output logic          ValidD
);

  fetch_state_t  state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic          discard_q, discard_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [PW-1:0] pcd_q, pcd_d;
  logic          valid_q, valid_d;

  logic          in_req, in_wait, in_hold;
  logic          ack_take, ack_keep;
  logic          buf_load, buf_clear;
  logic          wait_fresh, hold_fresh, fresh_vld;
  logic [IW-1:0] buf_instr, fresh_instr;
  logic [PW-1:0] buf_pc, fresh_pc;

  assign in_req  = (state_q == REQ);
  assign in_wait = (state_q == WAIT);
  assign in_hold = (state_q == HOLD);

  // Acks are only meaningful in WAIT; a stale (discarded) or redirected one is dropped.
  assign ack_take   = in_wait && imem_ack;
  assign ack_keep   = ack_take && !discard_q && !PCSrcE;
  assign buf_load   = ack_keep && StallD;
  assign wait_fresh = ack_keep && !StallD;
  assign hold_fresh = in_hold && !PCSrcE && !StallD;
  assign buf_clear  = in_hold && (PCSrcE || !StallD);
  assign fresh_vld  = wait_fresh || hold_fresh;

  assign fresh_instr = hold_fresh ? buf_instr : imem_rdata;
  assign fresh_pc    = hold_fresh ? buf_pc    : pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: begin
        if (imem_ack) begin
          state_d = buf_load ? HOLD : REQ;
        end
      end
      HOLD: begin
        if (PCSrcE || !StallD) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = in_req;
    imem_addr = pc_q;
  end

  // A redirect always wins the PC, even while Decode is stalled.
  always_comb begin
    pc_d      = pc_q;
    discard_d = discard_q;
    if (PCSrcE) begin
      pc_d = PCTargetE;
    end else if (fresh_vld) begin
      pc_d = pc_q + PW'(1);
    end
    if (ack_take) begin
      discard_d = 1'b0;
    end else if (PCSrcE && (in_req || in_wait)) begin
      discard_d = 1'b1;
    end
  end

  // Decode samples every cycle, so anything other than hold or a fresh load is a bubble.
  always_comb begin
    instr_d = IW'(NOP_INSTR);
    pcd_d   = '0;
    valid_d = 1'b0;
    if (FlushD) begin
      instr_d = IW'(NOP_INSTR);
      pcd_d   = '0;
      valid_d = 1'b0;
    end else if (StallD) begin
      instr_d = instr_q;
      pcd_d   = pcd_q;
      valid_d = valid_q;
    end else if (fresh_vld) begin
      instr_d = fresh_instr;
      pcd_d   = fresh_pc;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      instr_q   <= '0;
      pcd_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
      instr_q   <= instr_d;
      pcd_q     <= pcd_d;
      valid_q   <= valid_d;
    end
  end

  fetch_buffer #(
    .IW (IW),
    .PW (PW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (reset),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .instr_i (imem_rdata),
    .pc_i    (pc_q),
    .instr_o (buf_instr),
    .pc_o    (buf_pc)
  );

  assign InstrD = instr_q;
  assign PCD    = pcd_q;
  assign ValidD = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a variable-latency memory model answers
// requests, directed scenarios push expected IF/ID contents, a monitor checks them.
module tb_fetch_stage;

  localparam int IW = 20;
  localparam int PW = 15;

  logic          clk;
  logic          reset;
  logic          StallD, FlushD, PCSrcE;
  logic [PW-1:0] PCTargetE;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] InstrD;
  logic [PW-1:0] PCD;
  logic          ValidD;

  fetch_stage #(
    .IW       (IW),
    .PW       (PW),
    .RESET_PC (15'h0010)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .ValidD     (ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [IW+PW-1:0] exp_q[$];
  int               mem_lat    = 1;
  int               mem_budget = 0;
  logic             force_vld  = 1'b0;
  logic [IW-1:0]    force_data = '0;
  int               exp_gap    = -1;
  logic             hold_edge  = 1'b0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
  endtask

  // Whether the edge just taken should have held IF/ID.
  always @(posedge clk) hold_edge <= StallD && !FlushD;

  // Memory: default word is {5'h15, addr}; a one-shot override replaces the next response.
  initial begin : mem_model
    logic [PW-1:0] a;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset && imem_req && mem_budget > 0) begin
        a = imem_addr;
        mem_budget--;
        repeat (mem_lat) @(posedge clk);
        #1;
        imem_ack   = 1'b1;
        imem_rdata = force_vld ? force_data : {5'h15, a};
        force_vld  = 1'b0;
        @(posedge clk);
        #1;
        imem_ack   = 1'b0;
        imem_rdata = '0;
      end
    end
  end

  initial begin : monitor
    logic [IW-1:0]    last_i;
    logic [PW-1:0]    last_p;
    logic             last_v;
    logic [IW+PW-1:0] e;
    int               gap;
    bit               have_prev;
    gap = 0; have_prev = 0; last_i = '0; last_p = '0; last_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        gap = 0;
        have_prev = 0;
      end else begin
        if (hold_edge) begin
          check(InstrD == last_i && PCD == last_p && ValidD == last_v, "stall_hold",
                64'({ValidD, InstrD, PCD}), 64'({last_v, last_i, last_p}));
        end else if (ValidD) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_valid", 64'({InstrD, PCD}), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check({InstrD, PCD} == e, "instr_pc", 64'({InstrD, PCD}), 64'(e));
          end
          if (have_prev && exp_gap >= 0)
            check(gap == exp_gap, "bubble_gap", 64'(gap), 64'(exp_gap));
          have_prev = 1;
          gap = 0;
        end else begin
          check(InstrD == '0 && PCD == '0, "bubble_zero", 64'({InstrD, PCD}), 64'(0));
          gap++;
        end
        last_i = InstrD;
        last_p = PCD;
        last_v = ValidD;
      end
    end
  end

  task automatic do_reset(input int lat, input int budget);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check(ValidD == 1'b0, "rst_valid", 64'(ValidD), 64'(0));
    check(InstrD == '0, "rst_instr", 64'(InstrD), 64'(0));
    check(PCD == '0, "rst_pcd", 64'(PCD), 64'(0));
    check(imem_req == 1'b0, "rst_req", 64'(imem_req), 64'(0));
    check(imem_addr == 15'h0010, "rst_addr", 64'(imem_addr), 64'(15'h0010));
    StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    mem_lat = lat; mem_budget = budget;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_req(input logic [PW-1:0] addr, input string name);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (imem_req) seen = 1;
    end
    check(seen && imem_addr == addr, name, 64'({seen, imem_addr}), 64'({1'b1, addr}));
  endtask

  task automatic wait_ack(input string name);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (imem_ack) seen = 1;
    end
    if (!seen) check(1'b0, name, 64'(0), 64'(1));
  endtask

  task automatic drain(input string name);
    repeat (25) @(negedge clk);
    check(exp_q.size() == 0, name, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin : stim
    reset = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;

    // 1-cycle memory: first request right after IDLE, instruction visible the cycle after ack.
    do_reset(1, 3);
    force_vld = 1'b1; force_data = 20'hABCDE; exp_gap = 1;
    exp_q.push_back({20'hABCDE, 15'h0010});
    exp_q.push_back({20'hA8011, 15'h0011});
    exp_q.push_back({20'hA8012, 15'h0012});
    @(negedge clk);
    check(imem_req == 1'b1 && imem_addr == 15'h0010, "first_req", 64'({imem_req, imem_addr}), 64'({1'b1, 15'h0010}));
    @(negedge clk);
    check(ValidD == 1'b0, "ack_cycle_bubble", 64'(ValidD), 64'(0));
    @(negedge clk);
    check(ValidD && InstrD == 20'hABCDE && PCD == 15'h0010, "first_instr",
          64'({ValidD, InstrD, PCD}), 64'({1'b1, 20'hABCDE, 15'h0010}));
    check(imem_req == 1'b1 && imem_addr == 15'h0011, "second_req", 64'({imem_req, imem_addr}), 64'({1'b1, 15'h0011}));
    drain("drain_lat1");

    // 3-cycle memory: three bubbles between consecutive instructions.
    do_reset(3, 3);
    exp_gap = 3;
    exp_q.push_back({20'hA8010, 15'h0010});
    exp_q.push_back({20'hA8011, 15'h0011});
    exp_q.push_back({20'hA8012, 15'h0012});
    drain("drain_lat3");

    // Stall for 4 cycles starting on an ack: buffered, then exactly one copy on release.
    do_reset(1, 3);
    exp_gap = -1;
    exp_q.push_back({20'hA8010, 15'h0010});
    exp_q.push_back({20'hA8011, 15'h0011});
    exp_q.push_back({20'hA8012, 15'h0012});
    wait_ack("stall_ack1_timeout");
    wait_ack("stall_ack2_timeout");
    StallD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check(imem_req == 1'b0, "stall_noreq", 64'(imem_req), 64'(0));
    end
    StallD = 1'b0;
    @(negedge clk);
    check(ValidD && InstrD == 20'hA8011 && PCD == 15'h0011, "stall_release",
          64'({ValidD, InstrD, PCD}), 64'({1'b1, 20'hA8011, 15'h0011}));
    drain("drain_stall");

    // Redirect while waiting: the late 20'h11111 response is dropped.
    do_reset(3, 2);
    force_vld = 1'b1; force_data = 20'h11111;
    exp_q.push_back({20'hA8200, 15'h0200});
    wait_req(15'h0010, "redir_req0");
    @(negedge clk);
    PCSrcE = 1'b1; PCTargetE = 15'h0200;
    @(negedge clk);
    PCSrcE = 1'b0;
    wait_req(15'h0200, "redir_target_req");
    drain("drain_redirect");

    // Redirect in REQ to 0x7FFF, then the PC wraps to 0x0000.
    do_reset(1, 3);
    exp_q.push_back({20'hAFFFF, 15'h7FFF});
    exp_q.push_back({20'hA8000, 15'h0000});
    wait_req(15'h0010, "wrap_req0");
    PCSrcE = 1'b1; PCTargetE = 15'h7FFF;
    @(negedge clk);
    PCSrcE = 1'b0;
    wait_req(15'h7FFF, "wrap_req_7fff");
    wait_req(15'h0000, "wrap_req_0000");
    drain("drain_wrap");

    // Flush and stall together on an ack: bubble now, buffered instruction later.
    do_reset(1, 2);
    exp_q.push_back({20'hA8010, 15'h0010});
    exp_q.push_back({20'hA8011, 15'h0011});
    wait_ack("flush_ack_timeout");
    FlushD = 1'b1; StallD = 1'b1;
    @(negedge clk);
    check(ValidD == 1'b0 && InstrD == '0, "flush_stall_bubble", 64'({ValidD, InstrD}), 64'(0));
    FlushD = 1'b0; StallD = 1'b0;
    @(negedge clk);
    check(ValidD && InstrD == 20'hA8010 && PCD == 15'h0010, "flush_buffered",
          64'({ValidD, InstrD, PCD}), 64'({1'b1, 20'hA8010, 15'h0010}));
    drain("drain_flush");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, required completion", n_total);
    $fatal(1);
  end

endmodule
